lcd_frame_ctrl: RTL and testbench

Parametrised HD44780-class character-LCD controller: a generalised successor to the team's fixed 16x2 figure-display FSM. After power-up it runs the init sequence, then on every figure-select change or refresh request it streams a ROWS x COLS frame, fetched from an external synchronous character ROM, to the LCD over the 8-bit parallel bus. It sits between the pet-state logic driving `sel` and the LCD pins.

---
 rtl/lcd_frame_ctrl_if.sv | 14 +
 rtl/lcd_frame_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_lcd_frame_ctrl.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/lcd_frame_ctrl_if.sv
// rtl/lcd_frame_ctrl_if.sv - LCD parallel bus plus character-ROM port of lcd_frame_ctrl
interface lcd_frame_ctrl_if #(
   parameter int AW = 11
);
   logic          rs;
   logic          rw;
   logic          enable;
   logic [7:0]    data;
   logic [AW-1:0] char_addr;
   logic [7:0]    char_data;

   modport master (output rs, rw, enable, data, char_addr, input char_data);
   modport slave  (input rs, rw, enable, data, char_addr, output char_data);
endinterface

// File: rtl/lcd_frame_ctrl.sv
// rtl/lcd_frame_ctrl.sv - HD44780 init plus ROWS x COLS frame streamer from a character ROM
// Define LCD_CGRAM_EN to load 64 CGRAM pattern bytes at the start of every frame.
module lcd_frame_ctrl #(
   parameter int SEL_W    = 4,
   parameter int ROWS     = 2,
   parameter int COLS     = 16,
   parameter int EN_CYC   = 25,
   parameter int CMD_WAIT = 2000,
   parameter int CLR_WAIT = 100000,
   parameter int PWR_WAIT = 1000000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [SEL_W-1:0] sel,
   input  logic             refresh,
   lcd_frame_ctrl_if.master bus,
   output logic             busy,
   output logic             done
);
   localparam int NCH = ROWS * COLS;
   localparam int PW  = $clog2(NCH > 64 ? NCH : 64);

   localparam logic [2:0] S_PWRUP = 3'd0, S_INIT = 3'd1, S_CGRAM = 3'd2,
                          S_LINE  = 3'd3, S_CHAR = 3'd4, S_IDLE  = 3'd5;
   localparam logic [1:0] P_FETCH = 2'd0, P_SETUP = 2'd1, P_PULSE = 2'd2, P_WAIT = 2'd3;

   localparam logic [31:0] PWR_LAST = 32'(PWR_WAIT - 1);
   localparam logic [31:0] EN_LAST  = 32'(EN_CYC - 1);
   localparam logic [31:0] CMD_LAST = 32'(CMD_WAIT - 1);
   localparam logic [31:0] CLR_LAST = 32'(CLR_WAIT - 1);
   localparam logic [6:0]  COL_LAST = 7'(COLS - 1);
   localparam logic [1:0]  ROW_LAST = 2'(ROWS - 1);

`ifdef LCD_CGRAM_EN
   localparam logic [2:0] S_FIRST   = S_CGRAM;
   localparam logic [7:0] FIRST_CMD = 8'h40;
   localparam logic       FIRST_CG  = 1'b1;
`else
   localparam logic [2:0] S_FIRST   = S_LINE;
   localparam logic [7:0] FIRST_CMD = 8'h80;
   localparam logic       FIRST_CG  = 1'b0;
`endif

   logic [2:0]       state;
   logic [1:0]       phase;
   logic [31:0]      cnt;
   logic [1:0]       step;
   logic [1:0]       row;
   logic [6:0]       col;
   logic [PW-1:0]    idx;
   logic             cg;
   logic [SEL_W-1:0] sel_q;
   logic             pending;
   logic             rs_q;
   logic             en_q;
   logic [7:0]       data_q;
   logic [31:0]      wait_last;
   logic             init_last;
   logic             idle_go;
   logic             frame_go;

   function automatic logic [7:0] init_cmd(input logic [1:0] s);
      case (s)
         2'd0:    return 8'h38;
         2'd1:    return 8'h0C;
         2'd2:    return 8'h01;
         default: return 8'h06;
      endcase
   endfunction

   function automatic logic [7:0] line_cmd(input logic [1:0] r);
      case (r)
         2'd0:    return 8'h80;
         2'd1:    return 8'hC0;
         2'd2:    return 8'h94;
         default: return 8'hD4;
      endcase
   endfunction

   assign wait_last = (!rs_q && data_q == 8'h01) ? CLR_LAST : CMD_LAST;
   assign init_last = (state == S_INIT) && (phase == P_WAIT) && (cnt == wait_last) && (step == 2'd3);
   assign idle_go   = (state == S_IDLE) && ((sel != sel_q) || refresh || pending);
   assign frame_go  = init_last || idle_go;

   assign busy          = (state != S_IDLE);
   assign bus.rs        = rs_q;
   assign bus.rw        = 1'b0;
   assign bus.enable    = en_q;
   assign bus.data      = data_q;
   // The address advances right after each byte is latched, so the ROM has settled long before the next fetch.
   assign bus.char_addr = {cg, sel_q, idx};

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= S_PWRUP;
         phase   <= P_SETUP;
         cnt     <= '0;
         step    <= '0;
         row     <= '0;
         col     <= '0;
         idx     <= '0;
         cg      <= 1'b0;
         sel_q   <= '0;
         pending <= 1'b0;
         rs_q    <= 1'b0;
         en_q    <= 1'b0;
         data_q  <= 8'h00;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         if (refresh && state != S_IDLE) pending <= 1'b1;
         case (state)
            S_PWRUP: begin
               if (cnt == PWR_LAST) begin
                  sel_q  <= sel;
                  state  <= S_INIT;
                  step   <= 2'd0;
                  rs_q   <= 1'b0;
                  data_q <= 8'h38;
                  phase  <= P_SETUP;
                  cnt    <= '0;
               end else begin
                  cnt <= cnt + 32'd1;
               end
            end
            S_IDLE: begin
               if (idle_go) begin
                  sel_q   <= sel;
                  pending <= 1'b0;
               end
            end
            default: begin
               case (phase)
                  P_FETCH: begin
                     rs_q   <= 1'b1;
                     data_q <= bus.char_data;
                     idx    <= idx + 1'b1;
                     phase  <= P_SETUP;
                  end
                  P_SETUP: begin
                     en_q  <= 1'b1;
                     cnt   <= '0;
                     phase <= P_PULSE;
                  end
                  P_PULSE: begin
                     if (cnt == EN_LAST) begin
                        en_q  <= 1'b0;
                        cnt   <= '0;
                        phase <= P_WAIT;
                     end else begin
                        cnt <= cnt + 32'd1;
                     end
                  end
                  default: begin
                     if (cnt != wait_last) begin
                        cnt <= cnt + 32'd1;
                     end else begin
                        cnt <= '0;
                        case (state)
                           S_INIT: begin
                              if (step != 2'd3) begin
                                 step   <= step + 2'd1;
                                 data_q <= init_cmd(step + 2'd1);
                                 phase  <= P_SETUP;
                              end
                           end
                           S_CGRAM: begin
                              if (rs_q && col == 7'd63) begin
                                 state  <= S_LINE;
                                 cg     <= 1'b0;
                                 idx    <= '0;
                                 rs_q   <= 1'b0;
                                 data_q <= line_cmd(row);
                                 phase  <= P_SETUP;
                              end else begin
                                 col   <= rs_q ? col + 7'd1 : 7'd0;
                                 phase <= P_FETCH;
                              end
                           end
                           S_LINE: begin
                              state <= S_CHAR;
                              col   <= '0;
                              phase <= P_FETCH;
                           end
                           S_CHAR: begin
                              if (col != COL_LAST) begin
                                 col   <= col + 7'd1;
                                 phase <= P_FETCH;
                              end else if (row != ROW_LAST) begin
                                 row    <= row + 2'd1;
                                 state  <= S_LINE;
                                 rs_q   <= 1'b0;
                                 data_q <= line_cmd(row + 2'd1);
                                 phase  <= P_SETUP;
                              end else begin
                                 state <= S_IDLE;
                                 done  <= 1'b1;
                              end
                           end
                           default: ;
                        endcase
                     end
                  end
               endcase
            end
         endcase
         if (frame_go) begin
            state  <= S_FIRST;
            phase  <= P_SETUP;
            cnt    <= '0;
            row    <= '0;
            idx    <= '0;
            cg     <= FIRST_CG;
            rs_q   <= 1'b0;
            data_q <= FIRST_CMD;
         end
      end
   end
endmodule

// File: tb/tb_lcd_frame_ctrl.sv
// tb/tb_lcd_frame_ctrl.sv - directed table-driven bench for lcd_frame_ctrl
module tb_lcd_frame_ctrl;
   localparam int SEL_W = 4, ROWS = 2, COLS = 16;
   localparam int EN_CYC = 2, CMD_WAIT = 4, CLR_WAIT = 8, PWR_WAIT = 10;
   localparam int AW = 11;
`ifdef LCD_CGRAM_EN
   localparam int FP = 99, FRAME_CYC = 789;
`else
   localparam int FP = 34, FRAME_CYC = 270;
`endif

   typedef struct { logic [7:0] data; logic rs; int gap; } vec_t;
   typedef struct { logic [7:0] data; logic rs; int cyc; logic [3:0] s; } ev_t;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic [SEL_W-1:0] sel = '0;
   logic             refresh = 1'b0;
   logic             busy, done;
   int               cyc, n_done, done_cyc, n_pass, n_tot, exp_done, d0;
   logic             en_prev;
   vec_t             tbl[$];
   ev_t              ev[$];

   lcd_frame_ctrl_if #(.AW(AW)) bus();

   lcd_frame_ctrl #(
      .SEL_W(SEL_W), .ROWS(ROWS), .COLS(COLS), .EN_CYC(EN_CYC),
      .CMD_WAIT(CMD_WAIT), .CLR_WAIT(CLR_WAIT), .PWR_WAIT(PWR_WAIT)
   ) dut (
      .clk(clk), .reset(reset), .sel(sel), .refresh(refresh),
      .bus(bus), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // ROM returns {cg, 0, idx}
   always_ff @(posedge clk) bus.char_data <= {bus.char_addr[AW-1], 1'b0, bus.char_addr[5:0]};

   always @(posedge clk) begin
      if (reset) cyc <= 0;
      else cyc <= cyc + 1;
   end

   always @(posedge clk) begin
      #1;
      if (reset) begin
         en_prev = 1'b0;
      end else begin
         if (bus.enable && !en_prev) ev.push_back('{bus.data, bus.rs, cyc, bus.char_addr[9:6]});
         if (done) begin
            n_done++;
            done_cyc = cyc;
         end
         en_prev = bus.enable;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic wait_done(input string name);
      int start = n_done;
      for (int i = 0; i < 3000 && n_done == start; i++) @(negedge clk);
      chk(name, 32'(n_done != start), 32'd1);
   endtask

   task automatic pulse_refresh();
      refresh = 1'b1;
      @(negedge clk);
      refresh = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_enable"}, 32'(bus.enable), 32'd0);
      chk({tag, "_rs"}, 32'(bus.rs), 32'd0);
      chk({tag, "_rw"}, 32'(bus.rw), 32'd0);
      chk({tag, "_data"}, 32'(bus.data), 32'd0);
      chk({tag, "_char_addr"}, 32'(bus.char_addr), 32'd0);
      chk({tag, "_done"}, 32'(done), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd1);
   endtask

   task automatic check_pulses(input int t0, input int n, input int e0, input int es, input string tag);
      for (int k = 0; k < n; k++) begin
         if (e0 + k >= ev.size()) break;
         chk($sformatf("%s_data[%0d]", tag, k), 32'(ev[e0+k].data), 32'(tbl[t0+k].data));
         chk($sformatf("%s_rs[%0d]", tag, k), 32'(ev[e0+k].rs), 32'(tbl[t0+k].rs));
         chk($sformatf("%s_sel[%0d]", tag, k), 32'(ev[e0+k].s), 32'(es));
         if (k > 0)
            chk($sformatf("%s_gap[%0d]", tag, k), 32'(ev[e0+k].cyc - ev[e0+k-1].cyc), 32'(tbl[t0+k].gap));
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      // gap = cycles between enable rises; first entry is absolute from reset release
      tbl.push_back('{8'h38, 1'b0, 11});
      tbl.push_back('{8'h0C, 1'b0, 7});
      tbl.push_back('{8'h01, 1'b0, 7});
      tbl.push_back('{8'h06, 1'b0, 11});
`ifdef LCD_CGRAM_EN
      tbl.push_back('{8'h40, 1'b0, 7});
      for (int i = 0; i < 64; i++) tbl.push_back('{8'(128 + i), 1'b1, 8});
      tbl.push_back('{8'h80, 1'b0, 7});
`else
      tbl.push_back('{8'h80, 1'b0, 7});
`endif
      for (int i = 0; i < 16; i++) tbl.push_back('{8'(i), 1'b1, 8});
      tbl.push_back('{8'hC0, 1'b0, 7});
      for (int i = 16; i < 32; i++) tbl.push_back('{8'(i), 1'b1, 8});
      exp_done = 0;
      foreach (tbl[i]) exp_done += tbl[i].gap;
      exp_done += EN_CYC + CMD_WAIT;

      // reset state and first frame
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("reset");
      ev.delete();
      reset = 1'b0;
      wait_done("first_frame_done");
      chk("first_done_cyc", 32'(done_cyc), 32'(exp_done));
      chk("first_busy_low", 32'(busy), 32'd0);
      chk("first_pulse_count", 32'(ev.size()), 32'(4 + FP));
      if (ev.size() > 4) begin
         chk("first_enable_rise", 32'(ev[0].cyc), 32'd11);
         chk("init_end_rise", 32'(ev[4].cyc), 32'd43);
         chk("frame_cycles", 32'(done_cyc - ev[4].cyc + 1), 32'(FRAME_CYC));
      end
      check_pulses(0, tbl.size(), 0, 0, "init");
      repeat (10) @(negedge clk);
      chk("idle_quiet", 32'(ev.size()), 32'(4 + FP));
      chk("idle_done_count", 32'(n_done), 32'd1);
      chk("idle_busy", 32'(busy), 32'd0);

      // refresh in idle, then two refreshes while busy
      ev.delete();
      d0 = n_done;
      pulse_refresh();
      chk("refresh_busy_rise", 32'(busy), 32'd1);
      repeat (30) @(negedge clk);
      pulse_refresh();
      repeat (40) @(negedge clk);
      pulse_refresh();
      wait_done("refresh_frame1");
      wait_done("refresh_frame2");
      repeat (20) @(negedge clk);
      chk("refresh_frames", 32'(n_done - d0), 32'd2);
      chk("refresh_pulses", 32'(ev.size()), 32'(2 * FP));
      chk("refresh_busy_low", 32'(busy), 32'd0);
      check_pulses(4, FP, 0, 0, "rf1");
      check_pulses(4, FP, FP, 0, "rf2");

      // sel change while busy
      ev.delete();
      pulse_refresh();
      repeat (20) @(negedge clk);
      sel = 4'd5;
      wait_done("sel_frame_a");
      chk("sel_a_busy_low", 32'(busy), 32'd0);
      @(negedge clk);
      chk("sel_b_start", 32'(busy), 32'd1);
      wait_done("sel_frame_b");
      chk("sel_pulses", 32'(ev.size()), 32'(2 * FP));
      check_pulses(4, FP, 0, 0, "sa");
      check_pulses(4, FP, FP, 5, "sb");
      repeat (5) @(negedge clk);

      // reset in the middle of an enable pulse
      pulse_refresh();
      for (int i = 0; i < 100 && !bus.enable; i++) @(negedge clk);
      chk("saw_enable", 32'(bus.enable), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      check_reset_outputs("midreset");
      @(negedge clk);
      ev.delete();
      reset = 1'b0;
      wait_done("rerun_done");
      chk("rerun_done_cyc", 32'(done_cyc), 32'(exp_done));
      chk("rerun_pulse_count", 32'(ev.size()), 32'(4 + FP));
      check_pulses(0, tbl.size(), 0, 5, "rerun");

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule
